// File: rtl/pedal_pkg.sv
// Shared definitions for the pedal input sampler: snapshot bit layout,
// handshake states and the debounce counter width helper.
package pedal_pkg;

  typedef enum logic {IDLE, HOLD} snap_state_e;

  localparam int LVL_LSB  = 0;
  localparam int GEAR_LSB = 30;

  // Rise and fall fields follow the level field, each NUM_CH bits wide.
  function automatic int rise_lsb(input int num_ch);
    return num_ch;
  endfunction

  function automatic int fall_lsb(input int num_ch);
    return 2 * num_ch;
  endfunction

  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: two-flop synchroniser feeding a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce_ch
  import pedal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1     <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1   <= raw;
      sync <= s1;
      // Any cycle where sync agrees with stable restarts the count.
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pedal_input_sampler.sv
// Debounced pedal/button sampler with gear lockout, sticky edge events and a
// req/valid/ack snapshot port for the processor.
module pedal_input_sampler
  import pedal_pkg::*;
#(
  parameter int                NUM_CH          = 3,
  parameter int                DEBOUNCE_CYCLES = 50000,
  parameter logic [NUM_CH-1:0] GAS_MASK        = 3'b110
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic [1:0]        gear,
  input  logic              snap_req,
  input  logic              snap_ack,
  output logic              snap_valid,
  output logic [31:0]       snap_data,
  output logic [NUM_CH-1:0] level,
  output logic              evt_any
);

  localparam int RL = rise_lsb(NUM_CH);
  localparam int FL = fall_lsb(NUM_CH);

  logic [NUM_CH-1:0] stable, masked, rise_now, fall_now;
  logic [NUM_CH-1:0] rise_pend, fall_pend, rise_clr, fall_clr;
  logic [31:0]       word;
  snap_state_e       state, nstate;
  logic              cap, clr;

  debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_CH-1:0] (
    .clock  (clock),
    .reset  (reset),
    .raw    (raw_in),
    .stable (stable)
  );

  assign masked   = stable & ~(GAS_MASK & {NUM_CH{gear[0]}});
  assign rise_now = masked & ~level;
  assign fall_now = ~masked & level;

  always_comb begin
    word = '0;
    word[LVL_LSB +: NUM_CH] = level;
    word[RL +: NUM_CH]      = rise_pend;
    word[FL +: NUM_CH]      = fall_pend;
    word[GEAR_LSB +: 2]     = gear;
  end

  always_comb begin
    nstate = state;
    cap    = 1'b0;
    clr    = 1'b0;
    case (state)
      IDLE: if (snap_req) begin
        cap    = 1'b1;
        nstate = HOLD;
      end
      HOLD: if (snap_ack) begin
        clr    = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Only bits reported in the held word are cleared; fresh events always win.
  assign rise_clr = clr ? snap_data[RL +: NUM_CH] : '0;
  assign fall_clr = clr ? snap_data[FL +: NUM_CH] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      level     <= '0;
      rise_pend <= '0;
      fall_pend <= '0;
      snap_data <= '0;
    end else begin
      state     <= nstate;
      level     <= masked;
      rise_pend <= (rise_pend & ~rise_clr) | rise_now;
      fall_pend <= (fall_pend & ~fall_clr) | fall_now;
      if (cap) snap_data <= word;
    end
  end

  assign snap_valid = (state == HOLD);
  assign evt_any    = |{rise_pend, fall_pend};

endmodule

// File: tb/tb_pedal_input_sampler.sv
// Directed bench for pedal_input_sampler with a short debounce window.
module tb_pedal_input_sampler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  raw_in = '0;
  logic [1:0]  gear = '0;
  logic        snap_req = 1'b0, snap_ack = 1'b0;
  logic        snap_valid;
  logic [31:0] snap_data;
  logic [2:0]  level;
  logic        evt_any;

  int n_chk = 0, n_pass = 0;

  pedal_input_sampler #(.NUM_CH(3), .DEBOUNCE_CYCLES(4), .GAS_MASK(3'b110)) dut (
    .clock(clock), .reset(reset), .raw_in(raw_in), .gear(gear),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(snap_valid),
    .snap_data(snap_data), .level(level), .evt_any(evt_any)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic snap(input string tag, input logic [31:0] exp);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk({tag, "_valid"}, {31'b0, snap_valid}, 32'd1);
    chk({tag, "_data"}, snap_data, exp);
  endtask

  task automatic ack(input string tag);
    snap_ack = 1'b1;
    tick();
    snap_ack = 1'b0;
    chk({tag, "_ackvalid"}, {31'b0, snap_valid}, 32'd0);
  endtask

  initial begin
    // 1: reset state and basic latency
    tick(2);
    chk("rst_valid", {31'b0, snap_valid}, 0);
    chk("rst_data", snap_data, 0);
    chk("rst_level", {29'b0, level}, 0);
    chk("rst_evt", {31'b0, evt_any}, 0);
    reset = 1'b1;
    raw_in = 3'b001;
    tick(6);
    chk("t1_lvl6", {29'b0, level}, 0);
    tick();
    chk("t1_lvl7", {29'b0, level}, 3'b001);
    snap("t1", 32'h0000_0009);
    ack("t1");
    chk("t1_evt", {31'b0, evt_any}, 0);

    // 2: short glitch rejected, 4-cycle pulse accepted
    raw_in = 3'b011; tick(3); raw_in = 3'b001;
    tick(10);
    chk("t2_glitch_lvl", {29'b0, level}, 3'b001);
    chk("t2_glitch_evt", {31'b0, evt_any}, 0);
    raw_in = 3'b011; tick(4); raw_in = 3'b001;
    tick(2);
    chk("t2_lvl_pre", {29'b0, level}, 3'b001);
    tick();
    chk("t2_lvl_hi", {29'b0, level}, 3'b011);
    tick(10);
    chk("t2_lvl_back", {29'b0, level}, 3'b001);
    chk("t2_evt", {31'b0, evt_any}, 1);
    snap("t2", 32'h0000_0091);
    ack("t2");

    // 3: gear lockout on gas channels
    gear = 2'b01; raw_in = 3'b110;
    tick(12);
    chk("t3_locked_lvl", {29'b0, level}, 0);
    snap("t3a", 32'h4000_0040);
    ack("t3a");
    chk("t3_noevt", {31'b0, evt_any}, 0);
    gear = 2'b00; tick();
    chk("t3_unlock_lvl", {29'b0, level}, 3'b110);
    chk("t3_unlock_evt", {31'b0, evt_any}, 1);
    snap("t3b", 32'h0000_0036);
    ack("t3b");
    gear = 2'b01; tick();
    chk("t3_relock_lvl", {29'b0, level}, 0);
    snap("t3c", 32'h4000_0180);
    ack("t3c");

    // 4: event during HOLD survives the ack
    gear = 2'b00; tick();
    snap("t4a", 32'h0000_0036);
    raw_in = 3'b111;
    snap_req = 1'b1;
    tick(7);
    snap_req = 1'b0;
    chk("t4_lvl", {29'b0, level}, 3'b111);
    chk("t4_frozen", snap_data, 32'h0000_0036);
    chk("t4_hold", {31'b0, snap_valid}, 1);
    ack("t4a");
    chk("t4_evt", {31'b0, evt_any}, 1);
    snap("t4b", 32'h0000_000F);
    ack("t4b");
    chk("t4_clear", {31'b0, evt_any}, 0);

    // 5: req + ack + new event in one HOLD cycle
    snap("t5a", 32'h0000_0007);
    snap_req = 1'b1; snap_ack = 1'b1; gear = 2'b01;
    tick();
    snap_req = 1'b0; snap_ack = 1'b0;
    chk("t5_idle", {31'b0, snap_valid}, 0);
    chk("t5_evt", {31'b0, evt_any}, 1);
    tick();
    chk("t5_nocap", {31'b0, snap_valid}, 0);
    chk("t5_olddata", snap_data, 32'h0000_0007);
    snap("t5b", 32'h4000_0181);
    ack("t5b");

    // 6: asynchronous reset during HOLD and mid-debounce
    gear = 2'b00; tick();
    snap("t6a", 32'h0000_0037);
    raw_in = 3'b000;
    tick(4);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", {31'b0, snap_valid}, 0);
    chk("t6_data", snap_data, 0);
    chk("t6_level", {29'b0, level}, 0);
    chk("t6_evt", {31'b0, evt_any}, 0);
    tick(2);
    reset = 1'b1;
    raw_in = 3'b001;
    tick(6);
    chk("t6_lvl6", {29'b0, level}, 0);
    tick();
    chk("t6_lvl7", {29'b0, level}, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pedal_input_sampler.md
Name: pedal_input_sampler

Overview:
Parametrised successor to the top-level pedal and gear input glue. It takes NUM_CH raw pedal or button lines from the Pmod header and passes each one through a synchroniser and a debounce filter. Gas channels are forced to 0 by a gear lockout. Rise and fall events are latched until read. The processor side reads a coherent 32-bit snapshot through a req/valid/ack handshake, which replaces the direct combinational wiring of JB into the regfile.

Parameters:
NUM_CH, 3, number of input channels; legal range 1..10.
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new level; must be >= 1.
GAS_MASK, 3'b110, NUM_CH-bit mask; a set bit marks a channel that is forced to 0 while gear[0]=1.

Ports:
clock  in  1  system clock (the processor clock domain).
reset  in  1  asynchronous, active-low reset.
raw_in  in  NUM_CH  asynchronous pedal/button lines.
gear  in  2  gear switches, already synchronous to clock.
snap_req  in  1  one-cycle snapshot request.
snap_ack  in  1  consumer accepts the snapshot.
snap_valid  out  1  snapshot held and valid.
snap_data  out  32  snapshot word.
level  out  NUM_CH  debounced, masked level of each channel.
evt_any  out  1  OR of all pending rise and fall bits.

Behaviour:
- Reset (reset=0, asynchronous): clear all synchroniser flops, stable levels, counters, level, pending bits, snap_valid and snap_data.
- Synchroniser:
  - Two flops per channel; the second-stage output is sync[i].
- Debounce, per channel:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - When sync[i]==stable[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and sync[i] still differs, stable[i]<=sync[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Masking:
  - masked[i] = stable[i] & ~(GAS_MASK[i] & gear[0]).
  - level <= masked, registered.
  - Latency from a raw_in edge to level is 3 + DEBOUNCE_CYCLES clock edges.
- Events:
  - level 0->1 sets rise_pend[i]; level 1->0 sets fall_pend[i].
  - A gear[0] transition that changes a masked level also generates an event.
  - Pending bits are sticky and are cleared only by the ack rule below.
- Snapshot format:
  - [NUM_CH-1:0] = level.
  - [2*NUM_CH-1:NUM_CH] = rise_pend.
  - [3*NUM_CH-1:2*NUM_CH] = fall_pend.
  - [31:30] = gear.
  - All other bits are 0.
- Handshake states: IDLE and HOLD.
  - IDLE: on snap_req, capture the word at that edge and go to HOLD; snap_valid=1 from the next cycle.
  - HOLD: snap_data is frozen. snap_req is ignored.
  - HOLD with snap_ack: go to IDLE and clear exactly the pending bits that were set in the captured word.
  - An event arriving in the same cycle as the ack, or during HOLD, remains pending.
  - snap_ack while in IDLE is ignored.
  - snap_req and snap_ack together in HOLD: the ack is processed, and the req is dropped.
- Counter wrap: counters never exceed DEBOUNCE_CYCLES-1; there is no overflow.
- Mid-operation reset: any HOLD is abandoned, and snap_valid falls asynchronously.

Decomposition:
- Shared package pedal_pkg holds:
  - snapshot bit-offset constants: LVL_LSB, RISE_LSB, FALL_LSB, GEAR_LSB=30;
  - SNAP_STATE enum {IDLE, HOLD};
  - the clog2-based counter-width function.
- One sub-module, debounce_ch: the 2-flop synchroniser, counter and stable flop for one channel, instantiated NUM_CH times via generate.
- Masking, events and the handshake stay in pedal_input_sampler.

Test Plan (NUM_CH=3, DEBOUNCE_CYCLES=4, GAS_MASK=3'b110):
1. Reset, then raw_in=3'b001 held -> level=001 exactly 7 edges later. A following snap_req gives snap_data=0x0000_0009 (level bit0, rise bit3) with snap_valid the next cycle.
2. A 3-cycle pulse on raw_in[1] -> level stays 000 and evt_any stays 0. A 4-cycle pulse -> level[1]=1, then returns to 0, with both rise_pend[1] and fall_pend[1] set.
3. raw_in=3'b110 stable, gear=2'b01 -> level=000 and no events. gear goes to 00 -> level=110 next edge and rise bits 4,5 are set. gear back to 01 -> fall bits 7,8 are set.
4. snap_req, then a new rise event on ch0 while in HOLD, then snap_ack -> snap_data stays frozen during HOLD, only the captured bits clear, and rise_pend[0] stays 1. A second snapshot shows bit3 set.
5. snap_req, snap_ack and a new event all in the same cycle of HOLD -> FSM goes to IDLE, the new event is retained, and no new snapshot is captured.
6. Assert reset=0 mid-debounce (counter=2) and during HOLD -> snap_valid=0 immediately, all outputs 0. After release, raw_in must again be held 4+3 edges before level changes.
